// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard scoreboard: stall, forwarding select, mult/div busy, stall counter
module hazard_scoreboard #(
   parameter int NUM_STAGES     = 3,
   parameter int WIDTH_T        = 3,
   parameter int REG_AW         = 5,
   parameter int MD_MULT_CYCLES = 5,
   parameter int MD_DIV_CYCLES  = 10,
   parameter int CNT_W          = 32,
   parameter int SEL_W          = $clog2(NUM_STAGES + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [REG_AW-1:0]  id_rs,
   input  logic [REG_AW-1:0]  id_rt,
   input  logic [WIDTH_T-1:0] id_tuse_rs,
   input  logic [WIDTH_T-1:0] id_tuse_rt,
   input  logic [REG_AW-1:0]  id_dst,
   input  logic [WIDTH_T-1:0] id_tnew,
   input  logic               id_is_md,
   input  logic               id_md_start,
   input  logic               id_md_div,
   input  logic               flush,
   output logic               stall,
   output logic [SEL_W-1:0]   fwd_sel_rs,
   output logic [SEL_W-1:0]   fwd_sel_rt,
   output logic               md_busy,
   output logic [CNT_W-1:0]   stall_count
);

   localparam int MD_MAX = (MD_DIV_CYCLES > MD_MULT_CYCLES) ? MD_DIV_CYCLES : MD_MULT_CYCLES;
   localparam int MD_W   = $clog2(MD_MAX + 1);

   // index i holds the producer now in stage i+1
   logic               ent_valid [NUM_STAGES];
   logic [REG_AW-1:0]  ent_dst   [NUM_STAGES];
   logic [WIDTH_T-1:0] ent_tnew  [NUM_STAGES];
   logic [MD_W-1:0]    md_cnt;

   logic               adv;
   logic               hit_rs, hit_rt;
   logic [WIDTH_T-1:0] hit_tnew_rs, hit_tnew_rt;
   logic [SEL_W-1:0]   hit_sel_rs, hit_sel_rt;
   logic               stall_rs, stall_rt;

   // scan oldest to youngest so the youngest match overwrites older ones
   always_comb begin
      hit_rs      = 1'b0;
      hit_rt      = 1'b0;
      hit_tnew_rs = '0;
      hit_tnew_rt = '0;
      hit_sel_rs  = '0;
      hit_sel_rt  = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (ent_valid[i] && ent_dst[i] != '0 && ent_dst[i] == id_rs && id_rs != '0) begin
            hit_rs      = 1'b1;
            hit_tnew_rs = ent_tnew[i];
            hit_sel_rs  = SEL_W'(i + 1);
         end
         if (ent_valid[i] && ent_dst[i] != '0 && ent_dst[i] == id_rt && id_rt != '0) begin
            hit_rt      = 1'b1;
            hit_tnew_rt = ent_tnew[i];
            hit_sel_rt  = SEL_W'(i + 1);
         end
      end
   end

   always_comb begin
      stall_rs   = hit_rs && (id_tuse_rs != '1) && (hit_tnew_rs > id_tuse_rs);
      stall_rt   = hit_rt && (id_tuse_rt != '1) && (hit_tnew_rt > id_tuse_rt);
      md_busy    = (md_cnt != '0);
      stall      = !flush && (stall_rs || stall_rt || (md_busy && id_valid && id_is_md));
      adv        = id_valid && !stall && !flush;
      fwd_sel_rs = (hit_rs && hit_tnew_rs == '0) ? hit_sel_rs : '0;
      fwd_sel_rt = (hit_rt && hit_tnew_rt == '0) ? hit_sel_rt : '0;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            ent_valid[i] <= 1'b0;
            ent_dst[i]   <= '0;
            ent_tnew[i]  <= '0;
         end
      end else begin
         ent_valid[0] <= adv;
         ent_dst[0]   <= adv ? id_dst : '0;
         ent_tnew[0]  <= (adv && id_tnew != '0) ? id_tnew - 1'b1 : '0;
         for (int i = 1; i < NUM_STAGES; i++) begin
            ent_valid[i] <= ent_valid[i-1];
            ent_dst[i]   <= ent_dst[i-1];
            ent_tnew[i]  <= (ent_tnew[i-1] != '0) ? ent_tnew[i-1] - 1'b1 : '0;
         end
      end
   end

   // a running mult/div keeps counting through a flush; only reset aborts it
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt <= '0;
      end else if (adv && id_md_start) begin
         md_cnt <= id_md_div ? MD_W'(MD_DIV_CYCLES) : MD_W'(MD_MULT_CYCLES);
      end else if (md_cnt != '0) begin
         md_cnt <= md_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall && stall_count != {CNT_W{1'b1}}) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the fixed EX/MEM hazard-stall logic. It keeps its own registered scoreboard of in-flight register writers, one entry per stage after ID, with a saturating Tnew countdown. It also contains an internal multiply/divide busy counter in place of an external busy flag. From these it produces the ID-stage stall, the ID-stage forwarding select and a stall performance counter, and sits beside the ID stage of the pipeline.

Parameters:
NUM_STAGES, 3, number of tracked producer stages after ID (1 = EX, 2 = MEM, 3 = WB, ...); minimum 1
WIDTH_T, 3, width of all Tuse/Tnew fields
REG_AW, 5, register address width
MD_MULT_CYCLES, 5, busy cycles loaded for MULT/MULTU/MTHI/MTLO
MD_DIV_CYCLES, 10, busy cycles loaded for DIV/DIVU
CNT_W, 32, stall counter width
SEL_W, $clog2(NUM_STAGES+1), forwarding select width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction (0 = bubble)
id_rs  in  REG_AW  rs address in ID
id_rt  in  REG_AW  rt address in ID
id_tuse_rs  in  WIDTH_T  Tuse of rs; all-ones = unused
id_tuse_rt  in  WIDTH_T  Tuse of rt; all-ones = unused
id_dst  in  REG_AW  destination register of ID instruction (0 = none)
id_tnew  in  WIDTH_T  Tnew of ID instruction measured at ID
id_is_md  in  1  ID instruction touches the mult/div unit
id_md_start  in  1  ID instruction starts a mult/div operation
id_md_div  in  1  started operation is a divide
flush  in  1  exception entry / ERET flush
stall  out  1  freeze PC and ID, insert bubble into EX
fwd_sel_rs  out  SEL_W  0 = GRF; k = forward from stage k
fwd_sel_rt  out  SEL_W  same encoding, for rt
md_busy  out  1  mult/div unit busy
stall_count  out  CNT_W  cycles with stall = 1, saturating

Behaviour:
- Entry k (1..NUM_STAGES) holds the registered fields {valid, dst, tnew}.
- "adv" means enable_id = id_valid & !stall & !flush.
- Every cycle without reset or flush:
  - entry1 <= adv ? {1, id_dst, sat0(id_tnew-1)} : {0, 0, 0}
  - entry[k+1] <= {entry[k].valid, entry[k].dst, sat0(entry[k].tnew-1)}
  - The last entry is discarded.
  - Entries never stall; only ID freezes.
- Match k for operand r: entry[k].valid && entry[k].dst != 0 && entry[k].dst == r && r != 0.
- Youngest match (smallest k) governs the operand; older matches are shadowed.
- stall_r = youngest match exists && entry[k].tnew > tuse_r. A tuse of all-ones never stalls.
- stall = !flush && (stall_rs || stall_rt || (md_busy && id_valid && id_is_md)).
- fwd_sel_r = k if the youngest match has tnew == 0, else 0. This output is combinational and independent of stall.
- Mult/div counter md_cnt:
  - On adv && id_md_start, load MD_DIV_CYCLES if id_md_div, else MD_MULT_CYCLES.
  - Otherwise decrement when non-zero.
  - md_busy = (md_cnt != 0).
  - A start cannot coincide with busy, because it stalls.
- flush:
  - Next cycle, all entries are {0, 0, 0}.
  - stall is forced to 0 combinationally in the flush cycle.
  - A start in the flush cycle is ignored.
  - An md_cnt already running keeps counting.
- stall_count += 1 each cycle stall = 1, saturating at 2^CNT_W - 1.
- Reset: all entries invalid, md_cnt = 0, stall_count = 0, hence stall = 0, fwd_sel_* = 0, md_busy = 0. Reset mid-operation aborts everything in the same edge.
- Simultaneous reset and flush: reset wins; the result is identical.
- All outputs except stall_count and md_busy are combinational from registered state plus ID inputs.

Test Plan:
1. Load-use: LW dst = 8, tnew = 3 accepted; next ID is ADDU rs = 8, tuse_rs = 1 -> stall = 1 for exactly 1 cycle (entry1.tnew = 2), then stall = 0 with fwd_sel_rs = 0 (entry2.tnew = 1); stall_count = 1.
2. Branch after ALU: ADDU dst = 9, tnew = 2; then BEQ rs = 9, tuse = 0 -> 1 stall cycle, then fwd_sel_rs = 2, stall = 0.
3. Shadowing: entry2 = {dst 5, tnew 0} and entry1 = {dst 5, tnew 1}; ID rt = 5, tuse_rt = 0 -> stall = 1 and fwd_sel_rt stays 0, not 2.
4. Register $0: producer dst = 0, tnew = 3; consumer rs = 0, tuse = 0 -> stall = 0, fwd_sel_rs = 0 on every cycle.
5. Mult/div: MULT start (5 cycles) then MFHI in ID -> md_busy high 5 cycles, stall = 1 for 5 cycles, stall_count = 5. Repeat with DIV -> 10 cycles.
6. Flush/reset:
   - Flush asserted during a load-use stall -> stall = 0 that cycle; next cycle all entries invalid and no stall for the same consumer.
   - Reset during a DIV -> md_busy = 0 next cycle and stall_count = 0.
